// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU operation enum and pipeline stage-control struct
// used by the execute pipeline and its hazard unit.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_WB} fwd_sel_e;

    // Control half of a stage register; operands travel beside it because
    // their width follows the XLEN parameter of the instantiating module.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       illegal;
        alu_op_e    aluop;
    } stage_ctrl_t;

    function automatic alu_op_e f3_to_aluop(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_hazard_unit.sv
// RAW hazard resolution for the ID stage: forwarding selects when FWD_EN=1,
// otherwise an interlock stall against writing EX/WB instructions.
module rv32i_hazard_unit
    import rv32i_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic       id_valid,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_use,
    input  logic       rs2_use,
    input  logic       ex_we,
    input  logic [4:0] ex_rd,
    input  logic       wb_we,
    input  logic [4:0] wb_rd,
    output fwd_sel_e   fwd_a_sel,
    output fwd_sel_e   fwd_b_sel,
    output logic       stall
);

    logic hit_ex_a, hit_ex_b, hit_wb_a, hit_wb_b;

    always_comb begin
        hit_ex_a  = rs1_use && (rs1 != 5'd0) && ex_we && (ex_rd == rs1);
        hit_ex_b  = rs2_use && (rs2 != 5'd0) && ex_we && (ex_rd == rs2);
        hit_wb_a  = rs1_use && (rs1 != 5'd0) && wb_we && (wb_rd == rs1);
        hit_wb_b  = rs2_use && (rs2 != 5'd0) && wb_we && (wb_rd == rs2);
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        stall     = 1'b0;
        if (FWD_EN) begin
            if (hit_ex_a)      fwd_a_sel = FWD_EX;
            else if (hit_wb_a) fwd_a_sel = FWD_WB;
            if (hit_ex_b)      fwd_b_sel = FWD_EX;
            else if (hit_wb_b) fwd_b_sel = FWD_WB;
        end else begin
            stall = id_valid && (hit_ex_a || hit_ex_b || hit_wb_a || hit_wb_b);
        end
    end

endmodule

// File: rtl/rv32i_exec_pipe.sv
// Three-stage (ID/EX/WB) RV32I OP, OP-IMM and LUI execute pipeline with an
// internal write-through register file and a retire counter.
module rv32i_exec_pipe
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic [31:0]                  inst,
    output logic                         wb_valid,
    output logic [$clog2(REG_COUNT)-1:0] wb_addr,
    output logic [XLEN-1:0]              wb_data,
    output logic                         illegal,
    output logic [CNT_W-1:0]             retire_cnt
);

    localparam int unsigned AW  = $clog2(REG_COUNT);
    localparam int unsigned SHW = $clog2(XLEN);

    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_inst_q, id_inst_d;
    stage_ctrl_t       ex_ctrl_q, ex_ctrl_d, id_ctrl;
    logic [XLEN-1:0]   ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, wb_ill_q, wb_ill_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   regs_q [REG_COUNT];
    logic [XLEN-1:0]   regs_d [REG_COUNT];

    logic [6:0]        opcode, f7;
    logic [2:0]        f3;
    logic [4:0]        rd_f, rs1_f, rs2_f, rs1_addr, rs2_addr;
    logic              legal, rs1_en, rs2_en, imm_en, alt, stall;
    logic [XLEN-1:0]   imm, op_a, op_b, rf_a, rf_b, alu_res;
    logic [SHW-1:0]    shamt;
    fwd_sel_e          fwd_a_sel, fwd_b_sel;

    // The WB write is visible to the ID read in the same cycle.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        if (a == 5'd0 || 32'(a) >= REG_COUNT) return '0;
        if (wb_we_q && wb_rd_q == a) return wb_data_q;
        return regs_q[a[AW-1:0]];
    endfunction

    always_comb begin
        opcode = id_inst_q[6:0];
        rd_f   = id_inst_q[11:7];
        f3     = id_inst_q[14:12];
        rs1_f  = id_inst_q[19:15];
        rs2_f  = id_inst_q[24:20];
        f7     = id_inst_q[31:25];
        legal  = 1'b0;
        rs1_en = 1'b0;
        rs2_en = 1'b0;
        imm_en = 1'b0;
        alt    = 1'b0;
        imm    = '0;
        case (opcode)
            OPC_OP: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                alt    = (f7 == F7_ALT);
                legal  = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_ADD || f3 == F3_SR));
            end
            OPC_OP_IMM: begin
                rs1_en = 1'b1;
                imm_en = 1'b1;
                imm    = XLEN'($signed(id_inst_q[31:20]));
                alt    = (f3 == F3_SR) && (f7 == F7_ALT);
                if (f3 == F3_SLL)     legal = (f7 == F7_BASE);
                else if (f3 == F3_SR) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                  legal = 1'b1;
            end
            OPC_LUI: begin
                imm_en = 1'b1;
                legal  = 1'b1;
                imm    = XLEN'($signed({id_inst_q[31:12], 12'h000}));
            end
            default: ;
        endcase
        if (32'(rd_f) >= REG_COUNT || (rs1_en && 32'(rs1_f) >= REG_COUNT)
            || (rs2_en && 32'(rs2_f) >= REG_COUNT))
            legal = 1'b0;
        rs1_addr = (legal && rs1_en) ? rs1_f : 5'd0;
        rs2_addr = (legal && rs2_en) ? rs2_f : 5'd0;
        id_ctrl  = '0;
        if (id_valid_q) begin
            id_ctrl.valid   = 1'b1;
            id_ctrl.illegal = !legal;
            id_ctrl.we      = legal && (rd_f != 5'd0);
            id_ctrl.rd      = legal ? rd_f : 5'd0;
            id_ctrl.aluop   = (opcode == OPC_LUI) ? ALU_ADD : f3_to_aluop(f3, alt);
        end
    end

    rv32i_hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
        .id_valid  (id_valid_q),
        .rs1       (rs1_addr),
        .rs2       (rs2_addr),
        .rs1_use   (legal && rs1_en),
        .rs2_use   (legal && rs2_en),
        .ex_we     (ex_ctrl_q.we),
        .ex_rd     (ex_ctrl_q.rd),
        .wb_we     (wb_we_q),
        .wb_rd     (wb_rd_q),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .stall     (stall)
    );

    always_comb begin
        rf_a = rf_read(rs1_addr);
        rf_b = rf_read(rs2_addr);
        case (fwd_a_sel)
            FWD_EX:  op_a = alu_res;
            FWD_WB:  op_a = wb_data_q;
            default: op_a = rf_a;
        endcase
        case (fwd_b_sel)
            FWD_EX:  op_b = alu_res;
            FWD_WB:  op_b = wb_data_q;
            default: op_b = rf_b;
        endcase
        if (imm_en) op_b = imm;
    end

    always_comb begin
        shamt   = ex_b_q[SHW-1:0];
        alu_res = ex_a_q + ex_b_q;
        case (ex_ctrl_q.aluop)
            ALU_SUB:  alu_res = ex_a_q - ex_b_q;
            ALU_SLL:  alu_res = ex_a_q << shamt;
            ALU_SLT:  alu_res = XLEN'($signed(ex_a_q) < $signed(ex_b_q));
            ALU_SLTU: alu_res = XLEN'(ex_a_q < ex_b_q);
            ALU_XOR:  alu_res = ex_a_q ^ ex_b_q;
            ALU_SRL:  alu_res = ex_a_q >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(ex_a_q) >>> shamt);
            ALU_OR:   alu_res = ex_a_q | ex_b_q;
            ALU_AND:  alu_res = ex_a_q & ex_b_q;
            default:  ;
        endcase
    end

    always_comb begin
        inst_ready = !stall;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        if (!stall) begin
            id_valid_d = inst_valid;
            if (inst_valid) id_inst_d = inst;
        end
        // A stalled ID slot sends a bubble into EX while it holds.
        ex_ctrl_d  = stall ? '0 : id_ctrl;
        ex_a_d     = stall ? '0 : op_a;
        ex_b_d     = stall ? '0 : op_b;
        wb_valid_d = ex_ctrl_q.valid;
        wb_we_d    = ex_ctrl_q.we;
        wb_ill_d   = ex_ctrl_q.illegal;
        wb_rd_d    = ex_ctrl_q.rd;
        wb_data_d  = alu_res;
        cnt_d      = cnt_q + CNT_W'(wb_valid_q);
        regs_d     = regs_q;
        if (wb_we_q) regs_d[wb_rd_q[AW-1:0]] = wb_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            ex_ctrl_q  <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_ill_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            regs_q     <= '{default: '0};
        end else begin
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_ill_q   <= wb_ill_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            cnt_q      <= cnt_d;
            regs_q     <= regs_d;
        end
    end

    assign wb_valid   = wb_we_q;
    assign wb_addr    = wb_rd_q[AW-1:0];
    assign wb_data    = wb_data_q;
    assign illegal    = wb_ill_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_rv32i_exec_pipe.sv
// Directed self-checking bench: forwarding, interlock and small-counter
// instances of rv32i_exec_pipe share one instruction stream.
module tb_rv32i_exec_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst;

    logic        rdy_f, wbv_f, ill_f;
    logic [4:0]  adr_f;
    logic [31:0] dat_f;
    logic [15:0] cnt_f;
    logic        rdy_s, wbv_s, ill_s;
    logic [4:0]  adr_s;
    logic [31:0] dat_s;
    logic [15:0] cnt_s;
    logic        rdy_c, wbv_c, ill_c;
    logic [4:0]  adr_c;
    logic [31:0] dat_c;
    logic [3:0]  cnt_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv32i_exec_pipe #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(rdy_f), .inst(inst),
        .wb_valid(wbv_f), .wb_addr(adr_f), .wb_data(dat_f), .illegal(ill_f), .retire_cnt(cnt_f)
    );

    rv32i_exec_pipe #(.FWD_EN(1'b0)) u_stall (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(rdy_s), .inst(inst),
        .wb_valid(wbv_s), .wb_addr(adr_s), .wb_data(dat_s), .illegal(ill_s), .retire_cnt(cnt_s)
    );

    rv32i_exec_pipe #(.CNT_W(4)) u_cnt (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(rdy_c), .inst(inst),
        .wb_valid(wbv_c), .wb_addr(adr_c), .wb_data(dat_c), .illegal(ill_c), .retire_cnt(cnt_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inst_valid = 1'b0;
        inst       = 32'h0000_0013;
        reset      = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        inst_valid = 1'b0;
        reset      = 1'b0;
        #1;
        tests++; if (wbv_f !== 1'b0) begin fails++; $display("FAIL reset_wbv: got %0b want 0", wbv_f); end
        tests++; if (dat_f !== 32'h0) begin fails++; $display("FAIL reset_data: got %0h want 0", dat_f); end
        tests++; if (adr_f !== 5'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", adr_f); end
        tests++; if (ill_f !== 1'b0) begin fails++; $display("FAIL reset_ill: got %0b want 0", ill_f); end
        tests++; if (cnt_f !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", cnt_f); end
        step();
        step();
        reset = 1'b1;
        #1;
        tests++; if (rdy_f !== 1'b1) begin fails++; $display("FAIL reset_rdy_f: got %0b want 1", rdy_f); end
        tests++; if (rdy_s !== 1'b1) begin fails++; $display("FAIL reset_rdy_s: got %0b want 1", rdy_s); end
    endtask

    task automatic test_fwd_pair();
        do_reset();
        inst_valid = 1'b1;
        inst       = 32'h0050_0093;
        step();
        inst = 32'h0010_8133;
        tests++; if (rdy_f !== 1'b1) begin fails++; $display("FAIL fwd_rdy0: got %0b want 1", rdy_f); end
        step();
        inst_valid = 1'b0;
        tests++; if (rdy_f !== 1'b1) begin fails++; $display("FAIL fwd_rdy1: got %0b want 1", rdy_f); end
        step();
        tests++; if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'd1, 32'd5})
            begin fails++; $display("FAIL fwd_x1: got v%0b x%0d=%0h want v1 x1=5", wbv_f, adr_f, dat_f); end
        step();
        tests++; if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'd2, 32'd10})
            begin fails++; $display("FAIL fwd_x2: got v%0b x%0d=%0h want v1 x2=a", wbv_f, adr_f, dat_f); end
        step();
        tests++; if (cnt_f !== 16'd2) begin fails++; $display("FAIL fwd_cnt: got %0d want 2", cnt_f); end
    endtask

    task automatic test_stall_pair();
        int lows;
        lows = 0;
        do_reset();
        inst_valid = 1'b1;
        inst       = 32'h0050_0093;
        step();
        inst = 32'h0010_8133;
        tests++; if (rdy_s !== 1'b1) begin fails++; $display("FAIL stall_rdy0: got %0b want 1", rdy_s); end
        step();
        inst_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (!rdy_s) lows++;
            if (c == 2) begin
                tests++; if ({wbv_s, adr_s, dat_s} !== {1'b1, 5'd1, 32'd5})
                    begin fails++; $display("FAIL stall_x1: got v%0b x%0d=%0h want v1 x1=5", wbv_s, adr_s, dat_s); end
            end
            if (c == 3 || c == 4) begin
                tests++; if (wbv_s !== 1'b0) begin fails++; $display("FAIL stall_bubble%0d: got %0b want 0", c, wbv_s); end
            end
            if (c == 5) begin
                tests++; if ({wbv_s, adr_s, dat_s} !== {1'b1, 5'd2, 32'd10})
                    begin fails++; $display("FAIL stall_x2: got v%0b x%0d=%0h want v1 x2=a", wbv_s, adr_s, dat_s); end
            end
            step();
        end
        tests++; if (lows !== 2) begin fails++; $display("FAIL stall_cycles: got %0d want 2", lows); end
        tests++; if (cnt_s !== 16'd2) begin fails++; $display("FAIL stall_cnt: got %0d want 2", cnt_s); end
    endtask

    task automatic test_x0();
        do_reset();
        inst_valid = 1'b1;
        inst       = 32'h0070_0013;
        step();
        inst = 32'h0000_01B3;
        step();
        inst_valid = 1'b0;
        tests++; if (rdy_s !== 1'b1) begin fails++; $display("FAIL x0_no_stall: got %0b want 1", rdy_s); end
        step();
        tests++; if ({wbv_f, ill_f} !== 2'b00) begin fails++; $display("FAIL x0_nowrite: got v%0b i%0b want 00", wbv_f, ill_f); end
        step();
        tests++; if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'd3, 32'd0})
            begin fails++; $display("FAIL x0_fwd: got v%0b x%0d=%0h want v1 x3=0", wbv_f, adr_f, dat_f); end
        tests++; if ({wbv_s, adr_s, dat_s} !== {1'b1, 5'd3, 32'd0})
            begin fails++; $display("FAIL x0_stallinst: got v%0b x%0d=%0h want v1 x3=0", wbv_s, adr_s, dat_s); end
        step();
        tests++; if (cnt_f !== 16'd2) begin fails++; $display("FAIL x0_cnt: got %0d want 2", cnt_f); end
    endtask

    task automatic test_illegal();
        do_reset();
        inst_valid = 1'b1;
        inst       = 32'h0000_007F;
        step();
        inst = 32'h4000_1033;
        step();
        inst = 32'h0050_0093;
        step();
        inst = 32'h0010_8133;
        tests++; if ({ill_f, wbv_f} !== 2'b10) begin fails++; $display("FAIL ill_opc: got i%0b v%0b want i1 v0", ill_f, wbv_f); end
        step();
        inst_valid = 1'b0;
        tests++; if ({ill_f, wbv_f} !== 2'b10) begin fails++; $display("FAIL ill_f7: got i%0b v%0b want i1 v0", ill_f, wbv_f); end
        step();
        tests++; if ({ill_f, wbv_f, adr_f, dat_f} !== {1'b0, 1'b1, 5'd1, 32'd5})
            begin fails++; $display("FAIL ill_after1: got i%0b v%0b x%0d=%0h want i0 v1 x1=5", ill_f, wbv_f, adr_f, dat_f); end
        step();
        tests++; if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'd2, 32'd10})
            begin fails++; $display("FAIL ill_after2: got v%0b x%0d=%0h want v1 x2=a", wbv_f, adr_f, dat_f); end
        step();
        tests++; if (cnt_f !== 16'd4) begin fails++; $display("FAIL ill_cnt: got %0d want 4", cnt_f); end
    endtask

    task automatic test_alu_chain();
        logic [31:0] prog [11] = '{32'h800002B7, 32'hFFF00313, 32'h4042D393, 32'h0062A433,
                                   32'h0062B4B3, 32'h40838533, 32'h009545B3, 32'h00159613,
                                   32'h006656B3, 32'h7F06E713, 32'h006777B3};
        logic [31:0] exp_d [11] = '{32'h80000000, 32'hFFFFFFFF, 32'hF8000000, 32'h00000001,
                                    32'h00000001, 32'hF7FFFFFF, 32'hF7FFFFFE, 32'hEFFFFFFC,
                                    32'h00000001, 32'h000007F1, 32'h000007F1};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            inst_valid = (i < 11);
            inst       = (i < 11) ? prog[i] : 32'h0000_0013;
            step();
            tests++; if (rdy_f !== 1'b1) begin fails++; $display("FAIL alu_rdy%0d: got %0b want 1", i, rdy_f); end
            if (i >= 2) begin
                tests++;
                if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'(i + 3), exp_d[i-2]}) begin
                    fails++;
                    $display("FAIL alu_wb%0d: got v%0b x%0d=%0h want v1 x%0d=%0h",
                             i - 2, wbv_f, adr_f, dat_f, i + 3, exp_d[i-2]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        inst_valid = 1'b1;
        inst       = 32'h0050_0093;
        step();
        inst = 32'h0090_0113;
        step();
        inst = 32'h0010_0193;
        step();
        inst_valid = 1'b0;
        tests++; if ({wbv_f, dat_f} !== {1'b1, 32'd5}) begin fails++; $display("FAIL mid_inflight: got v%0b %0h want v1 5", wbv_f, dat_f); end
        #2 reset = 1'b0;
        #1;
        tests++; if ({wbv_f, ill_f, adr_f, dat_f, cnt_f} !== '0)
            begin fails++; $display("FAIL mid_async: got v%0b i%0b x%0d=%0h c%0d want all 0", wbv_f, ill_f, adr_f, dat_f, cnt_f); end
        step();
        step();
        reset = 1'b1;
        #1;
        tests++; if ({rdy_f, rdy_s} !== 2'b11) begin fails++; $display("FAIL mid_rdy: got %0b%0b want 11", rdy_f, rdy_s); end
        inst_valid = 1'b1;
        inst       = 32'h0020_8233;
        step();
        inst = 32'h0031_82B3;
        tests++; if (wbv_f !== 1'b0) begin fails++; $display("FAIL mid_quiet0: got %0b want 0", wbv_f); end
        step();
        inst_valid = 1'b0;
        tests++; if (wbv_f !== 1'b0) begin fails++; $display("FAIL mid_quiet1: got %0b want 0", wbv_f); end
        step();
        tests++; if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'd4, 32'd0})
            begin fails++; $display("FAIL mid_x4: got v%0b x%0d=%0h want v1 x4=0", wbv_f, adr_f, dat_f); end
        step();
        tests++; if ({wbv_f, adr_f, dat_f} !== {1'b1, 5'd5, 32'd0})
            begin fails++; $display("FAIL mid_x5: got v%0b x%0d=%0h want v1 x5=0", wbv_f, adr_f, dat_f); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        inst_valid = 1'b1;
        inst       = 32'h0000_0013;
        for (int e = 0; e < 22; e++) begin
            step();
            if (e == 16) inst_valid = 1'b0;
            if (e == 17) begin
                tests++; if (cnt_c !== 4'd15) begin fails++; $display("FAIL wrap_15: got %0d want 15", cnt_c); end
            end
            if (e == 18) begin
                tests++; if (cnt_c !== 4'd0) begin fails++; $display("FAIL wrap_0: got %0d want 0", cnt_c); end
            end
            if (e >= 19) begin
                tests++; if (cnt_c !== 4'd1) begin fails++; $display("FAIL wrap_1_e%0d: got %0d want 1", e, cnt_c); end
            end
        end
        tests++; if (cnt_f !== 16'd17) begin fails++; $display("FAIL wide_cnt: got %0d want 17", cnt_f); end
    endtask

    initial begin
        reset      = 1'b0;
        inst_valid = 1'b0;
        inst       = 32'h0000_0013;
        test_reset();
        test_fwd_pair();
        test_stall_pair();
        test_x0();
        test_illegal();
        test_alu_chain();
        test_reset_midstream();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
